// File: rtl/video_pixel_sequencer_pkg.sv
// video_timing_pkg: default 640x480 timing, pipe bundles and colour-bar table.
// Shared by video_pixel_sequencer and its delay-line helper.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_FB_ADDR_W = 19;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    typedef struct packed {
        logic       active;
        logic       tpat;
        logic [2:0] bar;
    } pix_tag_t;

    localparam logic [11:0] BAR_COLORS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic int h_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        return BAR_COLORS[idx];
    endfunction

endpackage

// File: rtl/video_pixel_sequencer_sync_delay_line.sv
// sync_delay_line: fixed-depth shift register with a synchronous reset value.
// Flushes to rst_val_i on rst_i; otherwise shifts d_i through DEPTH stages.
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= rst_val_i;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_pixel_sequencer.sv
// video_pixel_sequencer: raster counters, framebuffer fetch, sync alignment.
// Optional colour-bar source: VIDEO_PIXEL_SEQUENCER_TEST_PATTERN_EN.
module video_pixel_sequencer
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_FP             = DEF_H_FP,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BP             = DEF_H_BP,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_FP             = DEF_V_FP,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BP             = DEF_V_BP,
    parameter int FB_ADDR_W        = DEF_FB_ADDR_W,
    parameter int FB_LATENCY       = 1,
    parameter int CONV_LATENCY     = 1,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 test_mode,
    output logic                 fb_rd_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [11:0]          fb_data,
    output logic [11:0]          pix_color,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 de_out,
    output logic                 frame_start
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int PIPE  = 2 + FB_LATENCY + CONV_LATENCY;
    localparam int DLAT  = 1 + FB_LATENCY;
    localparam logic SYNC_OFF = ~SYNC_ACTIVE_HIGH;

    logic [HW-1:0]        h_cnt_q, h_cnt_d;
    logic [VW-1:0]        v_cnt_q, v_cnt_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic                 rd_en_q, rd_en_d;
    logic                 fs_q, fs_d;
    logic [11:0]          pix_q, pix_d;

    logic act_s0, hs_on, vs_on, origin, tp_sel;
    logic [2:0] bar_s0;

    sync_bus_t sync_s0, sync_dly, sync_idle;
    pix_tag_t  tag_s0, tag_dly;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == HW'(H_TOT - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(V_TOT - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    // Stage 0: everything is gated by enable so a drop flushes the pipes.
    assign act_s0 = enable
                  && (h_cnt_q < HW'(H_ACTIVE))
                  && (v_cnt_q < VW'(V_ACTIVE));
    assign hs_on  = enable
                  && (h_cnt_q >= HW'(H_ACTIVE + H_FP))
                  && (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on  = enable
                  && (v_cnt_q >= VW'(V_ACTIVE + V_FP))
                  && (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
    assign origin = enable && (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef VIDEO_PIXEL_SEQUENCER_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = $clog2(BAR_W + 1);

    // Bar index tracks h_cnt incrementally to avoid a divider.
    logic [BW-1:0] sub_q, sub_d;
    logic [2:0]    bar_q, bar_d;

    always_comb begin
        sub_d = sub_q;
        bar_d = bar_q;
        if (h_cnt_d == '0) begin
            sub_d = '0;
            bar_d = '0;
        end else if (h_cnt_q < HW'(H_ACTIVE)) begin
            if (sub_q == BW'(BAR_W - 1)) begin
                sub_d = '0;
                bar_d = bar_q + 3'd1;
            end else begin
                sub_d = sub_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= '0;
            bar_q <= '0;
        end else begin
            sub_q <= sub_d;
            bar_q <= bar_d;
        end
    end

    assign tp_sel = test_mode;
    assign bar_s0 = bar_q;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign tp_sel = 1'b0;
    assign bar_s0 = 3'd0;
`endif

    always_comb begin
        addr_d = addr_q;
        if (!enable || origin) begin
            addr_d = '0;
        end else if (act_s0) begin
            addr_d = addr_q + FB_ADDR_W'(1);
        end
    end

    assign rd_en_d = act_s0 & ~tp_sel;
    assign fs_d    = origin;

    assign sync_idle = '{hsync: SYNC_OFF, vsync: SYNC_OFF, de: 1'b0};
    assign sync_s0   = '{hsync: hs_on ^ SYNC_OFF,
                         vsync: vs_on ^ SYNC_OFF,
                         de:    act_s0};
    assign tag_s0    = '{active: act_s0, tpat: tp_sel, bar: bar_s0};

    sync_delay_line #(
        .WIDTH ($bits(sync_bus_t)),
        .DEPTH (PIPE)
    ) u_sync_pipe (
        .clk_i     (clk),
        .rst_i     (rst),
        .rst_val_i (sync_idle),
        .d_i       (sync_s0),
        .q_o       (sync_dly)
    );

    // Tag arrives in the same clock as fb_data for that pixel.
    sync_delay_line #(
        .WIDTH ($bits(pix_tag_t)),
        .DEPTH (DLAT)
    ) u_tag_pipe (
        .clk_i     (clk),
        .rst_i     (rst),
        .rst_val_i ('0),
        .d_i       (tag_s0),
        .q_o       (tag_dly)
    );

    always_comb begin
        pix_d = 12'h000;
        if (tag_dly.active) begin
`ifdef VIDEO_PIXEL_SEQUENCER_TEST_PATTERN_EN
            if (tag_dly.tpat) begin
                pix_d = bar_color(tag_dly.bar);
            end else begin
                pix_d = fb_data;
            end
`else
            pix_d = fb_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            fs_q    <= 1'b0;
            pix_q   <= 12'h000;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            fs_q    <= fs_d;
            pix_q   <= pix_d;
        end
    end

    assign fb_rd_en    = rd_en_q;
    assign fb_addr     = addr_q;
    assign frame_start = fs_q;
    assign pix_color   = pix_q;
    assign hsync_out   = sync_dly.hsync;
    assign vsync_out   = sync_dly.vsync;
    assign de_out      = sync_dly.de;

endmodule

// File: tb/tb_video_pixel_sequencer.sv
// Scoreboard bench for video_pixel_sequencer on a reduced 16x6 raster.
// Expectations come from a cycle model of the raster and a 1-clock framebuffer.
module tb_video_pixel_sequencer;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FBL = 1, CONVL = 1;
    localparam int PIPE = 2 + FBL + CONVL;
    localparam logic SAH = 1'b0;
`ifdef VIDEO_PIXEL_SEQUENCER_TEST_PATTERN_EN
    localparam logic TP = 1'b1;
`else
    localparam logic TP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        test_mode = 1'b0;
    logic        fb_rd_en;
    logic [7:0]  fb_addr;
    logic [11:0] fb_data = 12'hBAD;
    logic [11:0] pix_color;
    logic        hsync_out, vsync_out, de_out, frame_start;

    always #5 clk = ~clk;

    video_pixel_sequencer #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .FB_ADDR_W (8), .FB_LATENCY (FBL), .CONV_LATENCY (CONVL),
        .SYNC_ACTIVE_HIGH (SAH)
    ) dut (
        .clk (clk), .rst (rst), .enable (enable), .test_mode (test_mode),
        .fb_rd_en (fb_rd_en), .fb_addr (fb_addr), .fb_data (fb_data),
        .pix_color (pix_color), .hsync_out (hsync_out),
        .vsync_out (vsync_out), .de_out (de_out),
        .frame_start (frame_start)
    );

    typedef struct { int due; logic rd; logic [7:0] addr; logic fs; } fbx_t;
    typedef struct { int due; logic [11:0] pix; } pix_t;
    typedef struct { int due; logic hs; logic vs; logic de; } syn_t;

    fbx_t qa[$];
    pix_t qp[$];
    syn_t qs[$];

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    int tests = 0, fails = 0, cyc = 0;
    int mh = 0, mv = 0;
    logic [7:0] maddr = 8'd0;
    logic       prev_rd = 1'b0;
    logic [7:0] prev_addr = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic act, hs, vs, org, tp;
        logic [7:0] na;
        logic [11:0] pe;
        fbx_t ea;
        pix_t ep;
        syn_t es;
        act = enable && (mh < HA) && (mv < VA);
        hs  = enable && (mh >= HA + HFP) && (mh < HA + HFP + HS);
        vs  = enable && (mv >= VA + VFP) && (mv < VA + VFP + VS);
        org = enable && (mh == 0) && (mv == 0);
        tp  = TP && test_mode;
        if (!enable || org) na = 8'd0;
        else if (act) na = maddr + 8'd1;
        else na = maddr;
        if (!act) pe = 12'h000;
        else if (tp) pe = bars[mh / (HA / 8)];
        else pe = {4'h5, na};
        qa.push_back('{cyc + 1, act && !tp, na, org});
        qp.push_back('{cyc + 2 + FBL, pe});
        qs.push_back('{cyc + PIPE, hs ? SAH : !SAH, vs ? SAH : !SAH, act});
        maddr = na;
        if (!enable) begin
            mh = 0; mv = 0;
        end else if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        @(posedge clk); #1; cyc++;
        fb_data = prev_rd ? {4'h5, prev_addr} : 12'hBAD;
        prev_rd = fb_rd_en;
        prev_addr = fb_addr;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ea = qa.pop_front();
            chk("fb_rd_en", fb_rd_en, ea.rd);
            chk("fb_addr", fb_addr, ea.addr);
            chk("frame_start", frame_start, ea.fs);
        end
        if (qp.size() > 0 && qp[0].due == cyc) begin
            ep = qp.pop_front();
            chk("pix_color", pix_color, ep.pix);
        end
        if (qs.size() > 0 && qs[0].due == cyc) begin
            es = qs.pop_front();
            chk("hsync_out", hsync_out, es.hs);
            chk("vsync_out", vsync_out, es.vs);
            chk("de_out", de_out, es.de);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        chk("rst_rd_en", fb_rd_en, 1'b0);
        chk("rst_addr", fb_addr, 8'd0);
        chk("rst_pix", pix_color, 12'h000);
        chk("rst_de", de_out, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_hsync", hsync_out, !SAH);
        chk("rst_vsync", vsync_out, !SAH);
        mh = 0; mv = 0; maddr = 8'd0;
        qa.delete(); qp.delete(); qs.delete();
        for (int d = 1; d <= 1 + FBL; d++) qp.push_back('{cyc + d, 12'h000});
        for (int d = 1; d < PIPE; d++) qs.push_back('{cyc + d, !SAH, !SAH, 1'b0});
        fb_data = 12'hBAD;
        prev_rd = 1'b0;
        prev_addr = 8'd0;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 3; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 2 * HT * VT + 20; i++) step();
        for (int i = 0; i < 2 * HT * VT && !(mh == 10 && mv == 3); i++) step();
        chk("reach_h10_v3", (mh == 10 && mv == 3), 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 60; i++) step();
        do_reset();
        for (int i = 0; i < HT * VT + 20; i++) step();
        test_mode = 1'b1;
        for (int i = 0; i < HT * VT + 20; i++) step();
        test_mode = 1'b0;
        for (int i = 0; i < 30; i++) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/video_pixel_sequencer.md
Name: video_pixel_sequencer

Overview:
- Raster timing and framebuffer-fetch controller that sequences the 12-bit→24-bit color conversion stage of the video output path.
- Generates h/v counters, framebuffer read address and read enable, and a blank-gated 12-bit pixel for the color converter.
- Delays hsync/vsync/de so they align with the converter's registered 24-bit output at the HDMI/VGA encoder input.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- FB_ADDR_W, 19, framebuffer address width; must satisfy 2^FB_ADDR_W ≥ H_ACTIVE*V_ACTIVE
- FB_LATENCY, 1, framebuffer read latency (clocks, ≥1)
- CONV_LATENCY, 1, downstream color converter latency (clocks)
- SYNC_ACTIVE_HIGH, 0, 0 = syncs active-low, 1 = active-high

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run raster; low = idle/flush
- test_mode  in  1  select test pattern (see Optional Feature)
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr  out  FB_ADDR_W  linear pixel address y*H_ACTIVE+x
- fb_data  in  12  RGB444 pixel, valid FB_LATENCY clocks after fb_rd_en
- pix_color  out  12  pixel to color converter (0 in blanking)
- hsync_out  out  1  hsync aligned to converter output
- vsync_out  out  1  vsync aligned to converter output
- de_out  out  1  data enable aligned to converter output
- frame_start  out  1  one-clock pulse when counter state (0,0) is issued

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset values: counters 0, fb_addr 0, fb_rd_en 0, pix_color 0, de_out 0, frame_start 0. hsync_out and vsync_out are at the inactive level (= ~SYNC_ACTIVE_HIGH). All delay-pipe stages hold inactive values.
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - While enable=0, h_cnt=v_cnt=0.
  - The clock in which enable is sampled high issues state (0,0).
  - h_cnt increments each clock and wraps H_TOT-1→0.
  - v_cnt increments on the h wrap and wraps V_TOT-1→0.
- Stage 0 decode from counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule on v_cnt.
  - frame_start is registered from (0,0)&&enable.
- Address:
  - Registered and incremental; no multiplier.
  - Resets to 0 at state (0,0) and increments after each active pixel.
  - fb_rd_en = registered active.
  - fb_addr and fb_rd_en appear at issue+1.
- Data:
  - fb_data is sampled at issue+1+FB_LATENCY.
  - pix_color is registered at issue+2+FB_LATENCY and forced to 0 when the delayed active flag is 0.
- Alignment:
  - hsync/vsync/de are delayed by PIPE = 2+FB_LATENCY+CONV_LATENCY (default 4).
  - de_out=1 exactly while the converter output carries an active pixel.
- enable deasserted mid-frame:
  - Next clock, counters return to 0 and fb_rd_en drops.
  - The pipe flushes with inactive values over PIPE clocks; no partial-line garbage on de_out.
  - Re-enable restarts at (0,0).
- rst mid-frame: all state returns to reset values on the next edge, overriding enable.
- No back-pressure: the framebuffer must honour the fixed latency.

Optional Feature:
- Macro: VIDEO_PIXEL_SEQUENCER_TEST_PATTERN_EN.
- Defined:
  - When test_mode=1, pix_color is replaced by 8 vertical color bars of width H_ACTIVE/8, bar index = x/(H_ACTIVE/8).
  - Bar colors in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - fb_rd_en is held 0. Latency and alignment are unchanged.
- Not defined: test_mode is ignored; framebuffer path only.

Decomposition:
- Package video_timing_pkg:
  - default 640x480 timing constants
  - H_TOT/V_TOT derivation functions
  - RGB444 color-bar constant array
- Sub-module sync_delay_line: parameterized width/depth shift register with synchronous reset value input. Used for the {hsync, vsync, de, active} pipes.

Test Plan:
- Reset release, enable=1 at cycle N: fb_addr=0, fb_rd_en=1 at N+1; de_out rises at N+4; frame_start pulses at N+1.
- One full line: de_out high 640 clocks, low 160. hsync_out low from active-pixel-656 output time for 96 clocks; fb_addr reaches 639 on line 0 and 640 on line 1's first pixel.
- Full frame: vsync_out low lines 490–491; fb_addr reaches 307199 at (639,479); counters wrap to (0,0) after 420000 clocks and frame_start repeats.
- Data path: fb_data = fb_addr[11:0] model → pix_color equals the expected address value, delayed correctly; pix_color=0 whenever de is low.
- enable dropped at h_cnt=300, v_cnt=10: fb_rd_en=0 next clock; de_out low within 4 clocks and stays low; re-enable restarts fb_addr at 0.
- Macro defined, test_mode=1: x=0→FFF, x=80→FF0, x=639→000; fb_rd_en stays 0.
